fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the control unit. It holds the PC and issues requests to a variable-latency instruction memory. It latches the returned word and presents its opcode field to the controller. When the datapath commits the instruction, it selects the next PC from the controller's jump/pcsrc decisions. A watchdog flags instruction memory that never responds.

---
 rtl/fetch_unit.sv | 81 ++++++++
 tb/tb_fetch_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: PC holder and instruction fetch stage with next-PC select and imem timeout watchdog.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        advance,
  input  logic        pcsrc,
  input  logic        jump,
  output logic [31:0] instr,
  output logic [4:0]  op,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  output logic [31:0] retired,
  output logic        fetch_err
);
  typedef enum logic [1:0] {FETCH, EXEC, ERR} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, ret_q, ret_d;
  logic [7:0]  wait_q, wait_d;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ret_d   = ret_q;
    wait_d  = wait_q;
    case (state_q)
      FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          wait_d  = '0;
          state_d = EXEC;
        end else begin
          wait_d  = wait_q + 8'd1;
          state_d = (wait_q == 8'(MAX_WAIT - 1)) ? ERR : FETCH;
        end
      end
      EXEC: begin
        if (advance) begin
          // jump outranks a taken branch
          pc_d    = jump  ? {pcplus4[31:29], instr_q[26:0], 2'b00} :
                    pcsrc ? pcplus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00} :
                            pcplus4;
          ret_d   = ret_q + 32'd1;
          state_d = FETCH;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ret_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ret_q   <= ret_d;
      wait_q  <= wait_d;
    end
  end
  assign imem_req    = state_q == FETCH;
  assign instr_valid = state_q == EXEC;
  assign fetch_err   = state_q == ERR;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pcplus4     = pc_q + 32'd4;
  assign instr       = instr_q;
  assign op          = instr_q[31:27];
  assign retired     = ret_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table, hand-built corner sequences and a random run against a behavioural model.
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int          MW  = 4;
  logic        clk = 0;
  logic        reset, imem_req, imem_ready, advance, pcsrc, jump, instr_valid, fetch_err;
  logic [31:0] imem_addr, imem_rdata, instr, pc, pcplus4, retired;
  logic [4:0]  op;
  int n_cmp = 0, n_bad = 0;
  int          m_st, m_wait;
  logic [31:0] m_pc, m_instr, m_ret;
  fetch_unit #(.RESET_PC(RPC), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .advance(advance),
    .pcsrc(pcsrc), .jump(jump), .instr(instr), .op(op), .instr_valid(instr_valid),
    .pc(pc), .pcplus4(pcplus4), .retired(retired), .fetch_err(fetch_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        rdy;
    logic [31:0] rd;
    logic        adv, ps, jp, val;
    logic [4:0]  op;
    logic [31:0] pc, ret;
  } vec_t;
  vec_t tv[$];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic rst, input logic rdy, input logic [31:0] rd,
                       input logic adv, input logic ps, input logic jp);
    reset = rst; imem_ready = rdy; imem_rdata = rd; advance = adv; pcsrc = ps; jump = jp;
  endtask
  // Reference: states 0=fetch 1=exec 2=error, advanced from the rules once per clock.
  task automatic step();
    logic [31:0] nxt;
    if (reset) begin
      m_st = 0; m_pc = RPC; m_instr = 0; m_ret = 0; m_wait = 0;
    end else if (m_st == 0) begin
      if (imem_ready) begin
        m_instr = imem_rdata; m_wait = 0; m_st = 1;
      end else begin
        m_wait++;
        if (m_wait >= MW) m_st = 2;
      end
    end else if (m_st == 1 && advance) begin
      nxt = m_pc + 4;
      if (jump) nxt = (nxt & 32'hE000_0000) | (32'(m_instr[26:0]) * 4);
      else if (pcsrc) nxt = nxt + 32'($signed(m_instr[15:0]) * 4);
      m_pc = nxt; m_ret = m_ret + 1; m_st = 0;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic check_model(input string tag);
    check({tag, "_pc"}, pc, m_pc);
    check({tag, "_addr"}, imem_addr, m_pc);
    check({tag, "_pc4"}, pcplus4, m_pc + 4);
    check({tag, "_instr"}, instr, m_instr);
    check({tag, "_op"}, 32'(op), 32'(m_instr[31:27]));
    check({tag, "_ret"}, retired, m_ret);
    check({tag, "_req"}, 32'(imem_req), 32'(m_st == 0));
    check({tag, "_valid"}, 32'(instr_valid), 32'(m_st == 1));
    check({tag, "_err"}, 32'(fetch_err), 32'(m_st == 2));
  endtask
  initial begin
    tv.push_back('{1, 32'h0800_0003, 0, 0, 0, 1, 5'h01, 32'h0, 1'h0 ? 32'd1 : 32'd0});
    tv.push_back('{0, 32'h0, 1, 0, 0, 0, 5'h01, 32'h4, 32'd1});
    tv.push_back('{1, 32'h0000_FFFD, 0, 0, 0, 1, 5'h00, 32'h4, 32'd1});
    tv.push_back('{0, 32'h0, 1, 1, 0, 0, 5'h00, 32'hFFFF_FFFC, 32'd2});
    tv.push_back('{1, 32'h0, 0, 0, 0, 1, 5'h00, 32'hFFFF_FFFC, 32'd2});
    tv.push_back('{0, 32'h0, 1, 0, 0, 0, 5'h00, 32'h0, 32'd3});
    tv.push_back('{1, 32'h0000_0040, 0, 0, 0, 1, 5'h00, 32'h0, 32'd3});
    tv.push_back('{0, 32'h0, 1, 0, 1, 0, 5'h00, 32'h100, 32'd4});
    tv.push_back('{1, 32'h0000_FFFE, 0, 0, 0, 1, 5'h00, 32'h100, 32'd4});
    tv.push_back('{0, 32'h0, 1, 1, 0, 0, 5'h00, 32'h0FC, 32'd5});
    tv.push_back('{1, 32'h0000_0040, 0, 0, 0, 1, 5'h00, 32'h0FC, 32'd5});
    tv.push_back('{0, 32'h0, 1, 0, 1, 0, 5'h00, 32'h100, 32'd6});
    tv.push_back('{1, 32'h0000_0010, 0, 0, 0, 1, 5'h00, 32'h100, 32'd6});
    tv.push_back('{0, 32'h0, 1, 1, 0, 0, 5'h00, 32'h144, 32'd7});
    tv.push_back('{1, 32'h0, 0, 0, 0, 1, 5'h00, 32'h144, 32'd7});
    tv.push_back('{0, 32'h0, 1, 0, 1, 0, 5'h00, 32'h0, 32'd8});
    tv.push_back('{1, 32'h0000_FFFD, 0, 0, 0, 1, 5'h00, 32'h0, 32'd8});
    tv.push_back('{0, 32'h0, 1, 1, 0, 0, 5'h00, 32'hFFFF_FFF8, 32'd9});
    tv.push_back('{1, 32'h0, 0, 0, 0, 1, 5'h00, 32'hFFFF_FFF8, 32'd9});
    tv.push_back('{0, 32'h0, 1, 0, 1, 0, 5'h00, 32'hE000_0000, 32'd10});
    tv.push_back('{1, 32'hF800_0040, 0, 0, 0, 1, 5'h1F, 32'hE000_0000, 32'd10});
    tv.push_back('{0, 32'h0, 1, 1, 1, 0, 5'h1F, 32'hE000_0100, 32'd11});
    tv.push_back('{0, 32'h0, 1, 1, 0, 0, 5'h1F, 32'hE000_0100, 32'd11});
    tv.push_back('{1, 32'h1000_0000, 0, 0, 0, 1, 5'h02, 32'hE000_0100, 32'd11});
    tv.push_back('{0, 32'h0, 0, 0, 0, 1, 5'h02, 32'hE000_0100, 32'd11});
    tv.push_back('{1, 32'hFFFF_FFFF, 0, 0, 0, 1, 5'h02, 32'hE000_0100, 32'd11});
    tv.push_back('{0, 32'h0, 1, 0, 0, 0, 5'h02, 32'hE000_0104, 32'd12});
    drive(1, 0, 0, 0, 0, 0);
    step(); step();
    drive(0, 0, 0, 0, 0, 0);
    check("rst_pc", pc, RPC);
    check("rst_addr", imem_addr, RPC);
    check("rst_req", 32'(imem_req), 1);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_op", 32'(op), 0);
    check("rst_ret", retired, 0);
    check("rst_err", 32'(fetch_err), 0);
    foreach (tv[i]) begin
      drive(0, tv[i].rdy, tv[i].rd, tv[i].adv, tv[i].ps, tv[i].jp);
      step();
      check($sformatf("vec%0d_pc", i), pc, tv[i].pc);
      check($sformatf("vec%0d_ret", i), retired, tv[i].ret);
      check($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(tv[i].val));
      check($sformatf("vec%0d_req", i), 32'(imem_req), 32'(!tv[i].val));
      check($sformatf("vec%0d_op", i), 32'(op), 32'(tv[i].op));
    end
    drive(1, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 1; i < MW; i++) begin
      step();
      check($sformatf("to_wait%0d_err", i), 32'(fetch_err), 0);
      check($sformatf("to_wait%0d_req", i), 32'(imem_req), 1);
    end
    step();
    check("to_err", 32'(fetch_err), 1);
    check("to_req", 32'(imem_req), 0);
    check("to_valid", 32'(instr_valid), 0);
    drive(0, 1, 32'h0800_0000, 1, 0, 0);
    step(); step();
    check("to_sticky_err", 32'(fetch_err), 1);
    check("to_sticky_req", 32'(imem_req), 0);
    check("to_sticky_pc", pc, RPC);
    check("to_sticky_ret", retired, 0);
    drive(1, 0, 0, 0, 0, 0);
    step();
    check("to_rst_err", 32'(fetch_err), 0);
    check("to_rst_pc", pc, RPC);
    check("to_rst_req", 32'(imem_req), 1);
    drive(0, 1, 32'h0000_0010, 0, 0, 0);
    step();
    drive(0, 0, 0, 1, 0, 1);
    step();
    drive(0, 1, 32'h0800_0000, 0, 0, 0);
    step();
    check("mx_pc", pc, 32'h40);
    check("mx_valid", 32'(instr_valid), 1);
    drive(1, 0, 0, 1, 1, 0);
    step();
    check("mx_rst_pc", pc, RPC);
    check("mx_rst_instr", instr, 0);
    check("mx_rst_ret", retired, 0);
    check("mx_rst_valid", 32'(instr_valid), 0);
    check("mx_rst_req", 32'(imem_req), 1);
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, $urandom,
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      step();
      check_model($sformatf("rnd%0d", i));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
